// File: rtl/seg_scan_driver_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
//   Shared constants for the seven-segment scan driver.
//   SEG_BLANK / AN_OFF : all-segments-off and all-anodes-off patterns
//                        (both active-low, so "off" is all ones).
//   HEX_SEG_TABLE      : hex digit -> {dp,g,f,e,d,c,b,a}, active-low, dp off.
// ---------------------------------------------------------------------------
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Entry [n] holds the segment pattern for hex digit n.
    localparam logic [15:0][7:0] HEX_SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
        8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

endpackage

// File: rtl/seg_scan_driver_hex_to_seg.sv
// ---------------------------------------------------------------------------
// hex_to_seg
//   Combinational hex-digit decoder for an active-low seven-segment display.
//   Ports:
//     nibble in  4  hex digit to show
//     seg    out 8  {dp,g,f,e,d,c,b,a}, active-low, dp always off
// ---------------------------------------------------------------------------
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//   Shows a 32-bit display word as 8 hex digits on a time-multiplexed,
//   active-low seven-segment display. One digit is lit per scan slot of
//   CLK_DIV clocks. New words are held in a pending register and adopted only
//   when the digit index wraps, so a frame never mixes two words.
//   Ports:
//     clk      in  1   system clock
//     rst      in  1   synchronous, active-high reset
//     data_in  in  32  display word
//     data_vld in  1   data_in valid this cycle
//     blank_en in  1   blank leading zero digits
//     an       out 8   digit enables, active-low (an[0] = least significant nibble)
//     seg      out 8   {dp,g,f,e,d,c,b,a}, active-low
//     frame    out 1   one-cycle pulse after the digit index wraps to 0
// ---------------------------------------------------------------------------
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_DIV  = 100000,
    parameter int N_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        data_vld,
    input  logic        blank_en,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [31:0]   pending;
    logic [31:0]   shown;
    logic          pend_flag;

    logic          tick;
    logic          boundary;
    logic [2:0]    msd;
    logic [3:0]    cur_nibble;
    logic [7:0]    dec_seg;
    logic          blank_digit;

    assign tick     = (presc == PW'(CLK_DIV - 1));
    assign boundary = tick && (idx == 3'(N_DIGITS - 1));

    // Highest nonzero nibble of the shown word; stays 0 for an all-zero word
    // so digit 0 still shows '0' when blanking.
    // NOTE: every signal assigned in always_comb gets a default first so that
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        msd = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (shown[4*i +: 4] != 4'd0) msd = 3'(i);
        end
    end

    assign cur_nibble  = shown[{idx, 2'b00} +: 4];
    assign blank_digit = blank_en && (idx > msd);

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // The output registers are loaded on each tick with the digit currently
    // addressed by idx, while idx moves on to the next slot. The last digit
    // of a frame is therefore latched on the same edge that adopts a new word,
    // and still uses the old word.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side reads the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            idx       <= 3'd0;
            pending   <= 32'd0;
            shown     <= 32'd0;
            pend_flag <= 1'b0;
            an        <= AN_OFF;
            seg       <= SEG_BLANK;
            frame     <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            frame <= boundary;

            if (tick) begin
                idx <= idx + 3'd1;
                an  <= ~(8'h01 << idx);
                seg <= blank_digit ? SEG_BLANK : dec_seg;
            end

            if (data_vld) pending <= data_in;

            // A write landing on the boundary bypasses pending entirely.
            if (boundary) begin
                pend_flag <= 1'b0;
                if (data_vld)       shown <= data_in;
                else if (pend_flag) shown <= pending;
            end else if (data_vld) begin
                pend_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
//   Self-checking bench for seg_scan_driver with CLK_DIV = 4. The reference
//   model works from the edge count since reset: every CLK_DIV-th edge is a
//   scan tick, tick n lights digit (n-1) mod 8, and words written during a
//   frame are queued, the newest one becoming visible at the frame wrap.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int CLK_DIV = 4;
    localparam int FRAME_CYCLES = CLK_DIV * 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        data_vld;
    logic        blank_en;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame;

    int n_checks = 0;
    int n_fails  = 0;

    // reference model state
    int          ecnt;
    logic [31:0] m_shown;
    logic [31:0] m_queue [$];
    logic [7:0]  m_an;
    logic [7:0]  m_seg;
    logic        m_frame;

    seg_scan_driver #(.CLK_DIV(CLK_DIV), .N_DIGITS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_vld (data_vld),
        .blank_en (blank_en),
        .an       (an),
        .seg      (seg),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] hex_pattern(input logic [3:0] h);
        case (h)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;
            4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;
            4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;
            4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;
            4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input logic [31:0] w, input int d, input logic b);
        int hi = 0;
        for (int i = 0; i < 8; i++)
            if (((w >> (4 * i)) & 32'hF) != 0) hi = i;
        if (b && d > hi) return 8'hFF;
        return hex_pattern(4'((w >> (4 * d)) & 32'hF));
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare all outputs.
    task automatic step(input logic r, input logic v, input logic [31:0] d, input logic b);
        bit tick;
        int digit;
        rst = r; data_vld = v; data_in = d; blank_en = b;
        @(posedge clk);
        if (r) begin
            ecnt = 0; m_shown = 32'd0; m_queue.delete();
            m_an = 8'hFF; m_seg = 8'hFF; m_frame = 1'b0;
        end else begin
            ecnt++;
            tick  = (ecnt % CLK_DIV) == 0;
            digit = ((ecnt / CLK_DIV) - 1) % 8;
            if (tick) begin
                m_an  = ~(8'h01 << digit);
                m_seg = exp_seg(m_shown, digit, b);
            end
            m_frame = tick && digit == 7;
            if (v) m_queue.push_back(d);
            if (m_frame && m_queue.size() > 0) begin
                m_shown = m_queue[$];
                m_queue.delete();
            end
        end
        #1;
        chk("an", 64'(an), 64'(m_an));
        chk("seg", 64'(seg), 64'(m_seg));
        chk("frame", 64'(frame), 64'(m_frame));
    endtask

    task automatic idle(input int n, input logic b);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, b);
    endtask

    // Wait (bounded) for a frame pulse, then record each digit's seg value
    // over the following frame; segs[8*i +: 8] is digit i.
    task automatic capture_frame(input logic b, output logic [63:0] segs);
        int w = 0;
        segs = '0;
        while (frame !== 1'b1 && w < 100) begin
            step(1'b0, 1'b0, 32'd0, b);
            w++;
        end
        chk("frame_wait", 64'(frame), 64'd1);
        for (int c = 0; c < FRAME_CYCLES; c++) begin
            step(1'b0, 1'b0, 32'd0, b);
            for (int i = 0; i < 8; i++)
                if (an == ~(8'h01 << i)) segs[8*i +: 8] = seg;
        end
    endtask

    initial begin
        logic [63:0] segs;
        logic [31:0] rd;
        logic        rb;
        int          gap;

        // 1. reset and first lit digit
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0);
        chk("rst_an", 64'(an), 64'hFF);
        chk("rst_seg", 64'(seg), 64'hFF);
        chk("rst_frame", 64'(frame), 64'd0);
        idle(3, 1'b0);
        chk("pre_tick_an", 64'(an), 64'hFF);
        idle(1, 1'b0);
        chk("first_an", 64'(an), 64'hFE);

        // 2. single write, no blanking
        idle(5, 1'b0);
        step(1'b0, 1'b1, 32'h0123ABCD, 1'b0);
        capture_frame(1'b0, segs);
        chk("word_0123ABCD", segs, 64'hC0F9A4B0_8883C6A1);

        // 3. leading-zero blanking
        step(1'b0, 1'b1, 32'h000000F0, 1'b1);
        capture_frame(1'b1, segs);
        capture_frame(1'b1, segs);
        chk("blank_F0", segs, 64'hFFFFFFFF_FFFF8EC0);
        step(1'b0, 1'b1, 32'h00000000, 1'b1);
        capture_frame(1'b1, segs);
        capture_frame(1'b1, segs);
        chk("blank_zero", segs, 64'hFFFFFFFF_FFFFFFC0);

        // 4. write on the exact boundary cycle, frame period
        while (((ecnt + 1) % FRAME_CYCLES) != 0) step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'h88888888, 1'b0);
        capture_frame(1'b0, segs);
        chk("boundary_88888888", segs, 64'h80808080_80808080);
        gap = 0;
        step(1'b0, 1'b0, 32'd0, 1'b0);
        gap++;
        while (frame !== 1'b1 && gap < 100) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            gap++;
        end
        chk("frame_period", 64'(gap), 64'(FRAME_CYCLES));

        // 5. two writes within one frame: last one wins
        idle(3, 1'b0);
        step(1'b0, 1'b1, 32'h11111111, 1'b0);
        idle(5, 1'b0);
        step(1'b0, 1'b1, 32'h22222222, 1'b0);
        capture_frame(1'b0, segs);
        chk("last_write_wins", segs, 64'hA4A4A4A4_A4A4A4A4);

        // 6. reset mid-frame discards pending data
        idle(6, 1'b0);
        step(1'b0, 1'b1, 32'h55555555, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        chk("midrst_an", 64'(an), 64'hFF);
        chk("midrst_seg", 64'(seg), 64'hFF);
        capture_frame(1'b0, segs);
        chk("midrst_frame1", segs, 64'hC0C0C0C0_C0C0C0C0);
        capture_frame(1'b0, segs);
        chk("midrst_frame2", segs, 64'hC0C0C0C0_C0C0C0C0);

        // randomized traffic against the model
        rb = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rd = $urandom;
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 2) == 0) rd[4*i +: 4] = 4'd0;
            if ($urandom_range(0, 49) == 0) rb = ~rb;
            step(($urandom_range(0, 399) == 0), ($urandom_range(0, 19) == 0), rd, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
